// File: rtl/eager_fork_pkg.sv
// -----------------------------------------------------------------------------
// eager_fork_pkg
// Shared constants for the eager fork. Only the optional stall counter
// (enabled by EAGER_FORK_STALL_CNT_EN) uses them: its width and the value at
// which it saturates.
// -----------------------------------------------------------------------------
package eager_fork_pkg;

  localparam int                     STALL_CNT_W   = 32;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

endpackage : eager_fork_pkg

// File: rtl/eager_fork_if.sv
// -----------------------------------------------------------------------------
// eager_fork_if
// Handshake bundle around the 1-to-SIZE eager fork.
//   ins        : input payload              (producer -> fork)
//   ins_valid  : input token valid          (producer -> fork)
//   ins_ready  : input token accepted       (fork -> producer)
//   outs       : SIZE payloads, slice i = [i*DATA_TYPE +: DATA_TYPE]
//   outs_valid : per-output valid           (fork -> consumers)
//   outs_ready : per-output consumer ready  (consumers -> fork)
// Modports: master = the fork itself, slave = the surrounding environment.
// -----------------------------------------------------------------------------
interface eager_fork_if #(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
);

  logic [DATA_TYPE-1:0]      ins;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [SIZE*DATA_TYPE-1:0] outs;
  logic [SIZE-1:0]           outs_valid;
  logic [SIZE-1:0]           outs_ready;

  modport master (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

  modport slave (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

endinterface : eager_fork_if

// File: rtl/eager_fork_transfer_reg.sv
// -----------------------------------------------------------------------------
// eager_fork_transfer_reg
// Per-output delivery tracker. One bit of state records whether this output
// has already handed over the current input token (SENT) or still owes it
// (PENDING).
//   clk, rst          : clock, synchronous active-high reset
//   ins_valid_i       : input token valid
//   outs_ready_i      : this output's consumer ready
//   token_consumed_i  : input token accepted this cycle (all outputs done)
//   outs_valid_o      : this output's valid
//   ready_term_o      : sent | outs_ready, one term of the top-level AND
// -----------------------------------------------------------------------------
module eager_fork_transfer_reg (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid_i,
  input  logic outs_ready_i,
  input  logic token_consumed_i,
  output logic outs_valid_o,
  output logic ready_term_o
);

  // sent_q = 1 is the SENT state, 0 is PENDING.
  logic sent_q;
  logic sent_d;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values; combinational blocks below use blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end

  // Next state. Consumption wins: if this output fires in the same cycle the
  // token is consumed, it goes straight back to PENDING for the next token.
  always_comb begin
    // NOTE: assigning a default first guarantees no latch is inferred.
    sent_d = sent_q;
    if (token_consumed_i) begin
      sent_d = 1'b0;
    end else if (outs_valid_o && outs_ready_i) begin
      sent_d = 1'b1;
    end
  end

  // Outputs. outs_valid depends only on ins_valid and state, never on
  // outs_ready, so consumers see no ready-to-valid combinational path.
  always_comb begin
    outs_valid_o = ins_valid_i & ~sent_q;
    ready_term_o = sent_q | outs_ready_i;
  end

endmodule : eager_fork_transfer_reg

// File: rtl/eager_fork.sv
// -----------------------------------------------------------------------------
// eager_fork
// 1-to-SIZE eager fork: broadcasts one input token to SIZE outputs. Each
// output fires as soon as its consumer is ready; the input is consumed once
// every output has taken its copy. Zero latency, no data storage.
//   clk, rst      : clock, synchronous active-high reset
//   bus (master)  : ins/ins_valid/ins_ready and outs/outs_valid/outs_ready
//   stall_cycles  : only with EAGER_FORK_STALL_CNT_EN defined; saturating
//                   count of cycles with ins_valid high and ins_ready low
// Optional feature macro: EAGER_FORK_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module eager_fork
  import eager_fork_pkg::*;
#(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  eager_fork_if.master           bus
`ifdef EAGER_FORK_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

  logic [SIZE-1:0] valid_w;
  logic [SIZE-1:0] ready_term_w;
  logic            token_consumed;

  // Every output slice carries the input payload unchanged.
  assign bus.outs       = {SIZE{bus.ins}};
  assign bus.outs_valid = valid_w;
  // Input is accepted once each output has either already delivered the
  // token or is delivering it right now.
  assign bus.ins_ready  = &ready_term_w;
  assign token_consumed = bus.ins_valid & bus.ins_ready;

  for (genvar i = 0; i < SIZE; i++) begin : g_out
    eager_fork_transfer_reg u_transfer_reg (
      .clk              (clk),
      .rst              (rst),
      .ins_valid_i      (bus.ins_valid),
      .outs_ready_i     (bus.outs_ready[i]),
      .token_consumed_i (token_consumed),
      .outs_valid_o     (valid_w[i]),
      .ready_term_o     (ready_term_w[i])
    );
  end

`ifdef EAGER_FORK_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q;

  // Observation only: never feeds back into the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.ins_valid && !bus.ins_ready && (stall_q != STALL_CNT_MAX)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule : eager_fork

// File: tb/tb_eager_fork.sv
// -----------------------------------------------------------------------------
// tb_eager_fork
// Two forks: u_dut2 (SIZE=2) takes the directed sequences, u_dut3 (SIZE=3)
// takes a randomized stream of back-to-back tokens. A token-count model
// checks every cycle: output i owes the current token while the number of
// copies it has received equals the number of tokens consumed so far.
// -----------------------------------------------------------------------------
module tb_eager_fork;

  localparam int DW   = 32;
  localparam int NTOK = 40;

  logic clk = 1'b0;
  logic rst2;
  logic rst3;

  int tests = 0;
  int fails = 0;

  eager_fork_if #(.SIZE(2), .DATA_TYPE(DW)) if2 ();
  eager_fork_if #(.SIZE(3), .DATA_TYPE(DW)) if3 ();

`ifdef EAGER_FORK_STALL_CNT_EN
  logic [31:0] stall2;
  logic [31:0] stall3;
`endif

  eager_fork #(.SIZE(2), .DATA_TYPE(DW)) u_dut2 (
    .clk          (clk),
    .rst          (rst2),
    .bus          (if2)
`ifdef EAGER_FORK_STALL_CNT_EN
    ,
    .stall_cycles (stall2)
`endif
  );

  eager_fork #(.SIZE(3), .DATA_TYPE(DW)) u_dut3 (
    .clk          (clk),
    .rst          (rst3),
    .bus          (if3)
`ifdef EAGER_FORK_STALL_CNT_EN
    ,
    .stall_cycles (stall3)
`endif
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Model state, index d: 0 = u_dut2, 1 = u_dut3
  // ---------------------------------------------------------------------------
  int          consumed [2];
  int          got      [2][3];
  logic [31:0] rx       [2][3][$];
  logic [31:0] exp_q    [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int d, input int n, input logic r, input logic [31:0] din,
                      input logic iv, input logic [2:0] ordy, input logic [2:0] ov,
                      input logic ir, input logic [95:0] od);
    logic [2:0] ev;
    logic       er;
    if (r) begin
      // Reset forgets partial delivery of the current token.
      for (int i = 0; i < n; i++) got[d][i] = consumed[d];
      return;
    end
    ev = '0;
    er = 1'b1;
    for (int i = 0; i < n; i++) begin
      ev[i] = iv && (got[d][i] == consumed[d]);
      er    = er && ((got[d][i] > consumed[d]) || ordy[i]);
    end
    check($sformatf("d%0d outs_valid", d), 64'(ov), 64'(ev));
    check($sformatf("d%0d ins_ready", d), 64'(ir), 64'(er));
    for (int i = 0; i < n; i++) begin
      if (ev[i]) check($sformatf("d%0d outs[%0d]", d, i), 64'(od[i*32 +: 32]), 64'(din));
      if (ev[i] && ordy[i]) begin
        got[d][i]++;
        rx[d][i].push_back(din);
      end
    end
    if (iv && er) consumed[d]++;
  endtask

  always @(negedge clk) begin
    step(0, 2, rst2, if2.ins, if2.ins_valid, {1'b0, if2.outs_ready}, {1'b0, if2.outs_valid},
         if2.ins_ready, {32'b0, if2.outs});
    step(1, 3, rst3, if3.ins, if3.ins_valid, if3.outs_ready, if3.outs_valid,
         if3.ins_ready, if3.outs);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] tok;
    logic        done;

    for (int d = 0; d < 2; d++) begin
      consumed[d] = 0;
      for (int i = 0; i < 3; i++) got[d][i] = 0;
    end

    rst2 = 1'b1; rst3 = 1'b1;
    if2.ins = '0; if2.ins_valid = 1'b1; if2.outs_ready = 2'b00;
    if3.ins = '0; if3.ins_valid = 1'b0; if3.outs_ready = 3'b000;

    // Reset held 2 cycles with a valid token waiting.
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("reset outs_valid", 64'(if2.outs_valid), 64'h3);
    check("reset ins_ready", 64'(if2.ins_ready), 64'h0);

    // Broadcast: both ready, passes in one cycle.
    next_cycle();
    if2.ins = 32'hCAFE_0001; if2.outs_ready = 2'b11;
    @(negedge clk);
    check("bcast out0", 64'(if2.outs[31:0]), 64'hCAFE_0001);
    check("bcast out1", 64'(if2.outs[63:32]), 64'hCAFE_0001);
    check("bcast valid", 64'(if2.outs_valid), 64'h3);
    check("bcast ins_ready", 64'(if2.ins_ready), 64'h1);

    // Staggered consumers.
    next_cycle();
    if2.ins = 32'h5; if2.outs_ready = 2'b01;
    @(negedge clk);
    check("stagger c0 valid", 64'(if2.outs_valid), 64'h3);
    check("stagger c0 ins_ready", 64'(if2.ins_ready), 64'h0);
    next_cycle();
    if2.outs_ready = 2'b10;
    @(negedge clk);
    check("stagger c1 valid", 64'(if2.outs_valid), 64'h2);
    check("stagger c1 ins_ready", 64'(if2.ins_ready), 64'h1);
    check("stagger out1 data", 64'(if2.outs[63:32]), 64'h5);
    next_cycle();
    if2.ins = 32'h7; if2.outs_ready = 2'b00;
    @(negedge clk);
    check("stagger cleared", 64'(if2.outs_valid), 64'h3);
    check("stagger out0 copies", 64'(rx[0][0].size()), 64'd2);
    check("stagger out1 copies", 64'(rx[0][1].size()), 64'd2);

    // Mid-token reset: output 0 fires, then reset, then re-offer.
    next_cycle();
    if2.outs_ready = 2'b01;
    @(negedge clk);
    check("midrst fire ins_ready", 64'(if2.ins_ready), 64'h0);
    next_cycle();
    if2.outs_ready = 2'b00;
    @(negedge clk);
    check("midrst sent valid", 64'(if2.outs_valid), 64'h2);
    next_cycle();
    rst2 = 1'b1;
    next_cycle();
    rst2 = 1'b0;
    @(negedge clk);
    check("midrst reoffer", 64'(if2.outs_valid), 64'h3);
    next_cycle();
    if2.outs_ready = 2'b11;
    @(negedge clk);
    check("midrst consume", 64'(if2.ins_ready), 64'h1);

    // ins_ready may be high with no valid token.
    next_cycle();
    if2.ins_valid = 1'b0;
    @(negedge clk);
    check("idle valid", 64'(if2.outs_valid), 64'h0);
    check("idle ins_ready", 64'(if2.ins_ready), 64'h1);

`ifdef EAGER_FORK_STALL_CNT_EN
    next_cycle();
    if2.outs_ready = 2'b00;
    rst2 = 1'b1;
    next_cycle();
    rst2 = 1'b0;
    if2.ins_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    if2.ins_valid = 1'b0;
    @(negedge clk);
    check("stall count 5", 64'(stall2), 64'd5);
    force u_dut2.stall_q = 32'hFFFF_FFFF;
    #1;
    release u_dut2.stall_q;
    next_cycle();
    if2.ins_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("stall saturated", 64'(stall2), 64'hFFFF_FFFF);
    next_cycle();
    if2.outs_ready = 2'b11;
    next_cycle();
    if2.ins_valid = 1'b0;
`endif

    // Randomized back-to-back tokens on the SIZE=3 fork.
    for (int t = 0; t < NTOK; t++) begin
      tok = (t < 3) ? 32'(t + 1) : $urandom;
      exp_q.push_back(tok);
      next_cycle();
      if ($urandom_range(3) == 0) begin
        if3.ins_valid  = 1'b0;
        if3.outs_ready = 3'($urandom_range(7));
        next_cycle();
      end
      if3.ins        = tok;
      if3.ins_valid  = 1'b1;
      if3.outs_ready = 3'($urandom_range(7));
      done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
        @(negedge clk);
        if (if3.ins_ready) begin
          done = 1'b1;
        end else begin
          next_cycle();
          if3.outs_ready = 3'($urandom_range(7));
        end
      end
      if (!done) begin
        check("d1 token accept timeout", 64'h0, 64'h1);
        break;
      end
    end
    next_cycle();
    if3.ins_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("d1 out%0d copies", i), 64'(rx[1][i].size()), 64'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < rx[1][i].size(); j++)
        check($sformatf("d1 out%0d token%0d", i, j), 64'(rx[1][i][j]), 64'(exp_q[j]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_eager_fork
